// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - HH:MM BCD edit-session controller for watch and alarm registers
// Turns button edges into a cursor-driven edit of a shadow value, committed with one load strobe.
module watch_set_ctrl #(
  parameter int BLINK_DIV = 250,
  parameter bit HOURS_24  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mode,
  input  logic        setValue,
  input  logic        upTime,
  input  logic        nextDigit,
  input  logic [15:0] curTime,
  input  logic [15:0] curAlarm,
  output logic [15:0] editValue,
  output logic        editActive,
  output logic [1:0]  cursor,
  output logic        blinkOn,
  output logic        holdTime,
  output logic        loadTime,
  output logic        loadAlarm
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  localparam logic [2:0] MODE_WATCH = 3'b000;
  localparam logic [2:0] MODE_ALARM = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic             set_prev;
  logic             up_prev;
  logic             next_prev;
  logic [2:0]       entry_mode;
  logic             target_alarm;
  logic [CNT_W-1:0] blink_cnt;

  logic [15:0] edit_value_q;
  logic        edit_active_q;
  logic [1:0]  cursor_q;
  logic        blink_on_q;
  logic        hold_time_q;
  logic        load_time_q;
  logic        load_alarm_q;

  logic set_rise;
  logic set_fall;
  logic up_rise;
  logic next_rise;
  logic mode_ok;

  assign set_rise  = setValue & ~set_prev;
  assign set_fall  = ~setValue & set_prev;
  assign up_rise   = upTime & ~up_prev;
  assign next_rise = nextDigit & ~next_prev;
  assign mode_ok   = (mode == MODE_WATCH) || (mode == MODE_ALARM);

  function automatic logic [3:0] h1_limit(input logic [3:0] h10);
    if (HOURS_24) return (h10 == 4'd2) ? 4'd3 : 4'd9;
    else          return (h10 == 4'd1) ? 4'd1 : 4'd9;
  endfunction

  // Out-of-range snapshot digits wrap to 0 on the next increment (>= compares).
  function automatic logic [15:0] bump(input logic [15:0] v, input logic [1:0] cur);
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] h10_max;
    h10     = v[15:12];
    h1      = v[11:8];
    m10     = v[7:4];
    m1      = v[3:0];
    h10_max = HOURS_24 ? 4'd2 : 4'd1;
    case (cur)
      2'd3: begin
        h10 = (h10 >= h10_max) ? 4'd0 : h10 + 4'd1;
        if (h1 > h1_limit(h10)) h1 = 4'd0;
      end
      2'd2:    h1  = (h1 >= h1_limit(h10)) ? 4'd0 : h1 + 4'd1;
      2'd1:    m10 = (m10 >= 4'd5) ? 4'd0 : m10 + 4'd1;
      default: m1  = (m1 >= 4'd9) ? 4'd0 : m1 + 4'd1;
    endcase
    return {h10, h1, m10, m1};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      set_prev      <= 1'b1;
      up_prev       <= 1'b1;
      next_prev     <= 1'b1;
      entry_mode    <= 3'b000;
      target_alarm  <= 1'b0;
      blink_cnt     <= '0;
      edit_value_q  <= 16'h0000;
      edit_active_q <= 1'b0;
      cursor_q      <= 2'd3;
      blink_on_q    <= 1'b0;
      hold_time_q   <= 1'b0;
      load_time_q   <= 1'b0;
      load_alarm_q  <= 1'b0;
    end else begin
      set_prev     <= setValue;
      up_prev      <= upTime;
      next_prev    <= nextDigit;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (set_rise && mode_ok) begin
            state         <= S_EDIT;
            entry_mode    <= mode;
            target_alarm  <= (mode == MODE_ALARM);
            edit_value_q  <= (mode == MODE_ALARM) ? curAlarm : curTime;
            edit_active_q <= 1'b1;
            cursor_q      <= 2'd3;
            blink_on_q    <= 1'b1;
            blink_cnt     <= '0;
            hold_time_q   <= (mode == MODE_WATCH);
          end
        end

        S_EDIT: begin
          // Leaving the entry mode abandons the session, even if setValue falls at the same time.
          if (mode != entry_mode) begin
            state         <= S_IDLE;
            edit_active_q <= 1'b0;
            cursor_q      <= 2'd3;
            blink_on_q    <= 1'b0;
            hold_time_q   <= 1'b0;
          end else if (set_fall) begin
            state        <= S_COMMIT;
            load_time_q  <= ~target_alarm;
            load_alarm_q <= target_alarm;
          end else begin
            if (up_rise)   edit_value_q <= bump(edit_value_q, cursor_q);
            if (next_rise) cursor_q     <= cursor_q - 2'd1;
            if (up_rise || next_rise) begin
              blink_on_q <= 1'b1;
              blink_cnt  <= '0;
            end else if (blink_cnt == BLINK_LAST) begin
              blink_on_q <= ~blink_on_q;
              blink_cnt  <= '0;
            end else begin
              blink_cnt <= blink_cnt + CNT_W'(1);
            end
          end
        end

        S_COMMIT: begin
          state         <= S_IDLE;
          edit_active_q <= 1'b0;
          cursor_q      <= 2'd3;
          blink_on_q    <= 1'b0;
          hold_time_q   <= 1'b0;
        end

        default: begin
          state         <= S_IDLE;
          edit_active_q <= 1'b0;
          cursor_q      <= 2'd3;
          blink_on_q    <= 1'b0;
          hold_time_q   <= 1'b0;
        end
      endcase
    end
  end

  assign editValue  = edit_value_q;
  assign editActive = edit_active_q;
  assign cursor     = cursor_q;
  assign blinkOn    = blink_on_q;
  assign holdTime   = hold_time_q;
  assign loadTime   = load_time_q;
  assign loadAlarm  = load_alarm_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - directed bench for watch_set_ctrl
`timescale 1ns/1ps
module tb_watch_set_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode;
  logic        setValue;
  logic        upTime;
  logic        nextDigit;
  logic [15:0] curTime;
  logic [15:0] curAlarm;
  logic [15:0] editValue;
  logic        editActive;
  logic [1:0]  cursor;
  logic        blinkOn;
  logic        holdTime;
  logic        loadTime;
  logic        loadAlarm;

  int checks   = 0;
  int failures = 0;
  int n_lt     = 0;
  int n_la     = 0;
  int n_both   = 0;
  int base_lt;
  int base_la;

  always #5 clk = ~clk;

  watch_set_ctrl #(
    .BLINK_DIV (4),
    .HOURS_24  (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .setValue   (setValue),
    .upTime     (upTime),
    .nextDigit  (nextDigit),
    .curTime    (curTime),
    .curAlarm   (curAlarm),
    .editValue  (editValue),
    .editActive (editActive),
    .cursor     (cursor),
    .blinkOn    (blinkOn),
    .holdTime   (holdTime),
    .loadTime   (loadTime),
    .loadAlarm  (loadAlarm)
  );

  always @(negedge clk) begin
    if (loadTime)              n_lt++;
    if (loadAlarm)             n_la++;
    if (loadTime && loadAlarm) n_both++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_up();
    upTime = 1'b1;
    step();
    upTime = 1'b0;
    step();
  endtask

  task automatic press_next();
    nextDigit = 1'b1;
    step();
    nextDigit = 1'b0;
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 3'b000;
    setValue  = 1'b0;
    upTime    = 1'b0;
    nextDigit = 1'b0;
    curTime   = 16'h0000;
    curAlarm  = 16'h0000;
    step();
    step();
    chk("rst_edit_value", editValue, 16'h0000);
    chk("rst_active",     16'(editActive), 16'd0);
    chk("rst_cursor",     16'(cursor), 16'd3);
    chk("rst_blink",      16'(blinkOn), 16'd0);
    chk("rst_hold",       16'(holdTime), 16'd0);
    chk("rst_loads",      16'({loadTime, loadAlarm}), 16'd0);
    reset_n = 1'b1;
    step();

    // Alarm edit: h10 0->1->2->0->1, h1 0->2, m10 0->1.
    mode     = 3'b010;
    curAlarm = 16'h0000;
    setValue = 1'b1;
    step();
    chk("t1_active", 16'(editActive), 16'd1);
    chk("t1_cursor", 16'(cursor), 16'd3);
    chk("t1_blink",  16'(blinkOn), 16'd1);
    chk("t1_hold",   16'(holdTime), 16'd0);
    chk("t1_snap",   editValue, 16'h0000);
    repeat (4) press_up();
    chk("t1_h10", editValue, 16'h1000);
    press_next();
    repeat (2) press_up();
    press_next();
    press_up();
    chk("t1_value",  editValue, 16'h1210);
    chk("t1_cursor1", 16'(cursor), 16'd1);
    base_lt  = n_lt;
    base_la  = n_la;
    setValue = 1'b0;
    step();
    chk("t1_commit_la",     16'(loadAlarm), 16'd1);
    chk("t1_commit_lt",     16'(loadTime), 16'd0);
    chk("t1_commit_active", 16'(editActive), 16'd1);
    step();
    chk("t1_idle_active", 16'(editActive), 16'd0);
    chk("t1_idle_cursor", 16'(cursor), 16'd3);
    chk("t1_retain",      editValue, 16'h1210);
    chk("t1_la_count",    16'(n_la - base_la), 16'd1);
    chk("t1_lt_count",    16'(n_lt - base_lt), 16'd0);

    // Watch edit on m1: 0959 -> 0950.
    mode     = 3'b000;
    curTime  = 16'h0959;
    setValue = 1'b1;
    step();
    chk("t2_snap", editValue, 16'h0959);
    chk("t2_hold", 16'(holdTime), 16'd1);
    repeat (3) press_next();
    chk("t2_cursor", 16'(cursor), 16'd0);
    press_up();
    chk("t2_value", editValue, 16'h0950);
    base_lt  = n_lt;
    base_la  = n_la;
    setValue = 1'b0;
    step();
    chk("t2_commit_lt",   16'(loadTime), 16'd1);
    chk("t2_commit_hold", 16'(holdTime), 16'd1);
    step();
    chk("t2_idle_hold", 16'(holdTime), 16'd0);
    chk("t2_lt_count",  16'(n_lt - base_lt), 16'd1);
    chk("t2_la_count",  16'(n_la - base_la), 16'd0);

    // Hour clamp and wrap limits.
    curTime  = 16'h1900;
    setValue = 1'b1;
    step();
    press_up();
    chk("t3_h10_clamp", editValue, 16'h2000);
    press_next();
    repeat (3) press_up();
    chk("t3_h1_max", editValue, 16'h2300);
    press_up();
    chk("t3_h1_wrap", editValue, 16'h2000);
    press_next();
    repeat (5) press_up();
    chk("t3_m10_max", editValue, 16'h2050);
    press_up();
    chk("t3_m10_wrap", editValue, 16'h2000);
    setValue = 1'b0;
    step();
    step();

    // Abort on mode change; no session in a non-editable mode.
    mode     = 3'b000;
    setValue = 1'b1;
    step();
    chk("t4_open", 16'(editActive), 16'd1);
    base_lt = n_lt;
    base_la = n_la;
    mode    = 3'b001;
    step();
    chk("t4_abort_active", 16'(editActive), 16'd0);
    chk("t4_abort_cursor", 16'(cursor), 16'd3);
    chk("t4_abort_hold",   16'(holdTime), 16'd0);
    setValue = 1'b0;
    step();
    step();
    setValue = 1'b1;
    step();
    chk("t4_bad_mode", 16'(editActive), 16'd0);
    setValue = 1'b0;
    step();
    chk("t4_no_loads", 16'((n_lt - base_lt) + (n_la - base_la)), 16'd0);

    // Same-cycle up and next at cursor 3.
    mode     = 3'b000;
    curTime  = 16'h0000;
    setValue = 1'b1;
    step();
    upTime    = 1'b1;
    nextDigit = 1'b1;
    step();
    chk("t5_value",  editValue, 16'h1000);
    chk("t5_cursor", 16'(cursor), 16'd2);
    upTime    = 1'b0;
    nextDigit = 1'b0;
    step();
    setValue = 1'b0;
    step();
    step();

    // Blink timing with BLINK_DIV=4.
    curTime  = 16'h0000;
    setValue = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      chk("t6_blink_period", 16'(blinkOn), 16'(((i / 4) % 2) == 0));
      if (i < 8) step();
    end
    repeat (4) step();
    chk("t6_blink_low", 16'(blinkOn), 16'd0);
    upTime = 1'b1;
    step();
    chk("t6_blink_forced", 16'(blinkOn), 16'd1);
    upTime = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_blink_hold", 16'(blinkOn), 16'd1);
    end
    step();
    chk("t6_blink_release", 16'(blinkOn), 16'd0);
    setValue = 1'b0;
    step();
    step();

    // Async reset mid-session, with setValue held through release.
    curTime  = 16'h0000;
    setValue = 1'b1;
    step();
    press_up();
    chk("t6_pre_reset", editValue, 16'h1000);
    base_lt = n_lt;
    base_la = n_la;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_active", 16'(editActive), 16'd0);
    chk("t6_rst_cursor", 16'(cursor), 16'd3);
    chk("t6_rst_value",  editValue, 16'h0000);
    chk("t6_rst_blink",  16'(blinkOn), 16'd0);
    chk("t6_rst_hold",   16'(holdTime), 16'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("t5_held_set", 16'(editActive), 16'd0);
    setValue = 1'b0;
    step();
    step();
    chk("t6_rst_no_loads", 16'((n_lt - base_lt) + (n_la - base_la)), 16'd0);
    chk("never_both_loads", 16'(n_both), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
